fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage sequencer that owns the architectural fetch PC and drives the instruction-memory request channel (sram-like req/addr_ok/data_ok).
- Takes the redirect target computed by the next-PC unit (NPC plus PC_Flush) and applies it safely while a fetch may be in flight. A stale response is discarded and a pending target is remembered.
- Presents the fetched instruction to ID through a valid/allowin handshake.
- Sits between the next-PC logic, the instruction cache/bus interface and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address of the first request after reset.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous reset, active low.
- redirect_valid  input  1  one-cycle pulse: fetch must restart at redirect_pc (branch/jump/jr taken, eret, exception).
- redirect_pc  input  32  redirect target, sampled only when redirect_valid=1.
- inst_req  output  1  instruction fetch request.
- inst_addr  output  32  fetch address, valid while inst_req=1.
- inst_addr_ok  input  1  request accepted this cycle (meaningful only with inst_req=1).
- inst_data_ok  input  1  read data returned this cycle.
- inst_rdata  input  32  returned instruction word.
- id_allowin  input  1  ID can accept an instruction this cycle.
- if_valid  output  1  if_pc/if_inst hold a valid instruction for ID.
- if_pc  output  32  PC of the presented instruction.
- if_inst  output  32  presented instruction word.
- fetch_busy  output  1  a request is accepted and its data has not returned (state WAIT).

Behaviour:
- All state regs reset asynchronously on resetn=0:
  - state=REQ, fetch_pc=RESET_PC, discard=0, pend_pc=0.
  - Output buffer cleared: if_valid=0, if_pc=0, if_inst=0.
- inst_req, inst_addr and fetch_busy are decoded from registered state only, with no combinational path from any input.
  - inst_req=1 iff state=REQ and resetn=1.
  - inst_addr=fetch_pc.
  - First request is visible in the first cycle after reset deasserts.
- One outstanding request maximum.
- Throughput: at least 3 cycles per instruction (REQ, WAIT, OUT) with zero-wait memory.
- States:
  - REQ: inst_req=1. On inst_addr_ok, go to WAIT. Once asserted, inst_req and inst_addr stay stable until addr_ok; the request is never retracted or re-addressed.
  - WAIT: inst_req=0. On inst_data_ok:
    - if discard=1: drop the data, clear discard, set fetch_pc=pend_pc, go to REQ.
    - else: load if_pc=fetch_pc and if_inst=inst_rdata, set if_valid=1, go to OUT.
  - OUT: if_valid=1. On id_allowin (handshake fires): set if_valid=0, fetch_pc=if_pc+4 (32-bit wrap, carry dropped), go to REQ.
- Redirect handling (redirect_valid=1), by state:
  - REQ with inst_addr_ok same cycle: the request counts as accepted. Set discard=1, pend_pc=redirect_pc, go to WAIT.
  - REQ without inst_addr_ok: keep requesting the old fetch_pc. Set discard=1, pend_pc=redirect_pc. The later WAIT response is dropped.
  - WAIT without inst_data_ok: set discard=1, pend_pc=redirect_pc.
  - WAIT with inst_data_ok same cycle: the returning data is dropped regardless of discard. Set fetch_pc=redirect_pc, discard=0, go to REQ.
  - OUT: the buffered instruction is killed even if id_allowin=1 the same cycle (redirect has priority; ID is flushed by the same event). Set if_valid=0, fetch_pc=redirect_pc, go to REQ.
- A redirect arriving while discard=1 overwrites pend_pc; the newest target always wins.
- Only the target is buffered, never a second request, so consecutive redirects never cause more than one discarded response.
- A mid-operation reset abandons any in-flight transaction. The memory side is reset by the same resetn.
- fetch_pc is never modified while state=REQ, except by reset.

Test Plan:
- Reset release, zero-wait memory (addr_ok and data_ok each 1 cycle after prior event), id_allowin=1 -> first inst_addr=BFC00000, then BFC00004, BFC00008; if_valid pulses every 3 cycles with matching if_pc.
- Redirect pulse to 80001000 during WAIT, data returns 2 cycles later -> that data is never presented (if_valid stays 0); next inst_addr=80001000; returned word shown with if_pc=80001000.
- Redirect to 1000 while REQ is stalled (addr_ok=0 for 3 cycles), then a second redirect to 2000 before data_ok -> inst_addr stays at the old PC until addr_ok; exactly one response is dropped; next request address=2000.
- OUT with id_allowin=0 for 4 cycles -> if_valid, if_pc and if_inst stay constant and inst_req=0; then redirect and id_allowin together -> instruction is not consumed, if_valid=0 next cycle, next inst_addr=redirect_pc.
- fetch_pc=FFFFFFFC accepted by ID -> next inst_addr=00000000.
- resetn asserted low during WAIT -> if_valid=0, inst_req=0 while low; after release, inst_addr=BFC00000 with discard cleared.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one instruction-memory request at a time,
// absorbs redirects while a fetch is in flight, and presents fetched words to ID.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q,  discard_d;
    logic [31:0] pend_pc_q,  pend_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_inst_q,  if_inst_d;

    // Request side is decoded from state only; resetn gating keeps the request low while in reset.
    assign inst_req   = resetn && (state_q == ST_REQ);
    assign inst_addr  = fetch_pc_q;
    assign fetch_busy = (state_q == ST_WAIT);
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_inst    = if_inst_q;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        pend_pc_d  = pend_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        case (state_q)
            ST_REQ: begin
                // The request stays on the old address; only the target is remembered.
                if (redirect_valid) begin
                    discard_d = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (inst_data_ok) begin
                    discard_d = 1'b0;
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                        state_d    = ST_REQ;
                    end else if (discard_q) begin
                        fetch_pc_d = pend_pc_q;
                        state_d    = ST_REQ;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = inst_rdata;
                        state_d    = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end

            ST_OUT: begin
                // A redirect kills the buffered instruction even if ID would take it this cycle.
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = redirect_pc;
                    state_d    = ST_REQ;
                end else if (id_allowin) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = if_pc_q + 32'd4;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            pend_pc_q  <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            pend_pc_q  <= pend_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a memory responder with programmable latencies, a transaction-level
// model of the fetch sequencer compared every cycle, and directed scenarios with literal checks.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_busy;

    fetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_allowin     (id_allowin),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .fetch_busy     (fetch_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder knobs
    int addr_wait = 0;
    int data_wait = 0;

    initial begin
        logic        outstanding;
        logic        saw_req;
        logic [31:0] saw_addr;
        logic [31:0] out_addr;
        int          req_cnt;
        int          wait_cnt;
        outstanding  = 1'b0;
        saw_req      = 1'b0;
        saw_addr     = '0;
        out_addr     = '0;
        req_cnt      = 0;
        wait_cnt     = 0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                outstanding  = 1'b0;
                saw_req      = 1'b0;
                req_cnt      = 0;
                wait_cnt     = 0;
                inst_addr_ok = 1'b0;
                inst_data_ok = 1'b0;
                inst_rdata   = 32'hDEAD_BEEF;
            end else begin
                if (inst_addr_ok && saw_req) begin
                    outstanding = 1'b1;
                    out_addr    = saw_addr;
                    wait_cnt    = 0;
                    req_cnt     = 0;
                end
                if (inst_data_ok) outstanding = 1'b0;
                saw_req      = inst_req;
                saw_addr     = inst_addr;
                inst_addr_ok = inst_req && (req_cnt >= addr_wait);
                if (inst_req && !inst_addr_ok) req_cnt++;
                inst_data_ok = outstanding && (wait_cnt >= data_wait);
                inst_rdata   = inst_data_ok ? mem_word(out_addr) : 32'hDEAD_BEEF;
                if (outstanding) wait_cnt++;
            end
        end
    end

    // Transaction-level model: where the next fetch goes, whether a response is owed and
    // whether it is wanted, and what instruction is on show to ID.
    logic [31:0] m_fetch;
    logic        m_in_flight;
    logic        m_want;
    logic [31:0] m_target;
    logic        m_show;
    logic [31:0] m_show_pc;
    logic [31:0] m_show_inst;

    logic [31:0] req_log[$];
    logic [31:0] show_log[$];
    logic [31:0] show_inst_log[$];
    int          show_cyc[$];
    logic [31:0] consumed_log[$];
    int          data_cnt = 0;
    int          cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                m_fetch     = RESET_PC;
                m_in_flight = 1'b0;
                m_want      = 1'b1;
                m_target    = '0;
                m_show      = 1'b0;
                m_show_pc   = '0;
                m_show_inst = '0;
            end else if (m_show) begin
                if (redirect_valid) begin
                    m_show  = 1'b0;
                    m_fetch = redirect_pc;
                end else if (id_allowin) begin
                    m_show  = 1'b0;
                    consumed_log.push_back(m_show_pc);
                    m_fetch = m_show_pc + 32'd4;
                end
            end else if (!m_in_flight) begin
                if (redirect_valid) begin
                    m_want   = 1'b0;
                    m_target = redirect_pc;
                end
                if (inst_addr_ok) begin
                    m_in_flight = 1'b1;
                    req_log.push_back(m_fetch);
                end
            end else if (inst_data_ok) begin
                data_cnt++;
                m_in_flight = 1'b0;
                if (redirect_valid) begin
                    m_fetch = redirect_pc;
                    m_want  = 1'b1;
                end else if (!m_want) begin
                    m_fetch = m_target;
                    m_want  = 1'b1;
                end else begin
                    m_show      = 1'b1;
                    m_show_pc   = m_fetch;
                    m_show_inst = inst_rdata;
                    show_log.push_back(m_fetch);
                    show_inst_log.push_back(inst_rdata);
                    show_cyc.push_back(cyc);
                end
            end else if (redirect_valid) begin
                m_want   = 1'b0;
                m_target = redirect_pc;
            end
            #1;
            check("inst_req", {31'd0, inst_req}, {31'd0, resetn && !m_in_flight && !m_show});
            if (inst_req) check("inst_addr", inst_addr, m_fetch);
            check("fetch_busy", {31'd0, fetch_busy}, {31'd0, resetn && m_in_flight});
            check("if_valid", {31'd0, if_valid}, {31'd0, m_show});
            check("if_pc", if_pc, m_show_pc);
            check("if_inst", if_inst, m_show_inst);
        end
    end

    task automatic clear_logs();
        req_log.delete();
        show_log.delete();
        show_inst_log.delete();
        show_cyc.delete();
        consumed_log.delete();
        data_cnt = 0;
    endtask

    task automatic do_reset(input int aw, input int dw, input logic allow);
        @(negedge clk);
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        addr_wait      = aw;
        data_wait      = dw;
        id_allowin     = allow;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_logs();
    endtask

    task automatic wait_busy(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = fetch_busy;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = if_valid;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_shows(input string name, input int n);
        logic ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (show_log.size() >= n);
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_reqs(input string name, input int n);
        logic ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (req_log.size() >= n);
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_allowin     = 1'b1;

        // Reset release, zero-wait memory, streaming fetch
        repeat (2) @(negedge clk);
        #1;
        check("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        #1;
        check("first_req", {31'd0, inst_req}, 32'd1);
        check("first_addr", inst_addr, 32'hBFC0_0000);
        wait_shows("s1_timeout", 3);
        if (show_log.size() >= 3 && req_log.size() >= 3) begin
            check("s1_req0", req_log[0], 32'hBFC0_0000);
            check("s1_req1", req_log[1], 32'hBFC0_0004);
            check("s1_req2", req_log[2], 32'hBFC0_0008);
            check("s1_show0", show_log[0], 32'hBFC0_0000);
            check("s1_inst0", show_inst_log[0], 32'h13E8_5BDF);
            check("s1_show2", show_log[2], 32'hBFC0_0008);
            check("s1_period", show_cyc[1] - show_cyc[0], 32'd3);
            check("s1_period2", show_cyc[2] - show_cyc[1], 32'd3);
        end

        // Redirect during WAIT, data two cycles later is dropped
        do_reset(0, 2, 1'b1);
        wait_busy("s2_busy_timeout");
        pulse_redirect(32'h8000_1000);
        wait_shows("s2_timeout", 1);
        if (show_log.size() >= 1) begin
            check("s2_show_pc", show_log[0], 32'h8000_1000);
            check("s2_show_inst", show_inst_log[0], 32'h13D7_9BCF);
            check("s2_req1", req_log[1], 32'h8000_1000);
            check("s2_dropped", data_cnt, 32'd2);
        end

        // Redirects while REQ is stalled and then in WAIT: one response dropped, newest wins
        do_reset(3, 2, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        @(posedge clk);
        #1;
        check("s3_hold_req", {31'd0, inst_req}, 32'd1);
        check("s3_hold_addr", inst_addr, 32'hBFC0_0000);
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_busy("s3_busy_timeout");
        pulse_redirect(32'h0000_2000);
        wait_shows("s3_timeout", 1);
        if (show_log.size() >= 1 && req_log.size() >= 2) begin
            check("s3_req0", req_log[0], 32'hBFC0_0000);
            check("s3_req1", req_log[1], 32'h0000_2000);
            check("s3_show_pc", show_log[0], 32'h0000_2000);
            check("s3_responses", data_cnt, 32'd2);
        end

        // OUT stalled by ID, then redirect with allowin in the same cycle
        do_reset(0, 0, 1'b0);
        wait_valid("s4_valid_timeout");
        held_pc   = if_pc;
        held_inst = if_inst;
        check("s4_pc", held_pc, 32'hBFC0_0000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("s4_hold_valid", {31'd0, if_valid}, 32'd1);
            check("s4_hold_pc", if_pc, held_pc);
            check("s4_hold_inst", if_inst, held_inst);
            check("s4_no_req", {31'd0, inst_req}, 32'd0);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        id_allowin     = 1'b1;
        @(posedge clk);
        #1;
        check("s4_killed", {31'd0, if_valid}, 32'd0);
        check("s4_req", {31'd0, inst_req}, 32'd1);
        check("s4_addr", inst_addr, 32'h0000_4000);
        check("s4_not_consumed", consumed_log.size(), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;

        // PC wrap from FFFFFFFC to 00000000
        do_reset(0, 0, 1'b1);
        wait_valid("s5_valid_timeout");
        pulse_redirect(32'hFFFF_FFFC);
        clear_logs();
        wait_reqs("s5_timeout", 2);
        if (req_log.size() >= 2 && show_log.size() >= 1) begin
            check("s5_req0", req_log[0], 32'hFFFF_FFFC);
            check("s5_inst", show_inst_log[0], 32'hEFA8_6420);
            check("s5_req_wrap", req_log[1], 32'h0000_0000);
        end

        // Reset during WAIT with a pending discard
        do_reset(0, 3, 1'b1);
        wait_busy("s6_busy_timeout");
        pulse_redirect(32'h0000_3000);
        resetn    = 1'b0;
        data_wait = 0;
        #1;
        check("s6_rst_req", {31'd0, inst_req}, 32'd0);
        check("s6_rst_valid", {31'd0, if_valid}, 32'd0);
        check("s6_rst_busy", {31'd0, fetch_busy}, 32'd0);
        @(posedge clk);
        #1;
        check("s6_rst_req2", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        #1;
        check("s6_req", {31'd0, inst_req}, 32'd1);
        check("s6_addr", inst_addr, 32'hBFC0_0000);
        wait_shows("s6_timeout", 1);
        if (show_log.size() >= 1) begin
            check("s6_show_pc", show_log[0], 32'hBFC0_0000);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
